fifo_stream_reader: RTL and testbench

- Read-side client for the team's pop/valid FIFOs (pop request, rdata/valid returned a fixed latency later). Never stalls returned data.
- Issues pops against fifo_empty and absorbs returned words into a small skid buffer.
- Presents the words on a valid/ready stream with optional frame delimiting (m_last).
- Sits between any regular FIFO and a backpressuring consumer.

---
 rtl/fifo_stream_reader.sv | 116 +++++++++++
 tb/tb_fifo_stream_reader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
`timescale 1ns/1ps
// Read-side adapter for fixed-latency pop/valid FIFOs: issues credit-limited pops,
// catches returned words in a skid buffer and presents them as a valid/ready stream.
module fifo_stream_reader #(
    parameter int WIDTH     = 16,
    parameter int RD_LAT    = 1,
    parameter int DEPTH     = 2,
    parameter int FRAME_LEN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             idle,
    output logic             err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [RD_LAT-1:0] infl_q, infl_d;
    logic              err_q, err_d;
    logic [IW-1:0]     infl_cnt;
    logic              exp_vld, deq, enq, ovf, wr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + IW'(infl_q[i]);
    end

    assign exp_vld = infl_q[RD_LAT-1];
    assign m_valid = (occ_q != '0);
    assign m_data  = mem_q[head_q];
    assign deq     = m_valid && m_ready;
    assign idle    = (occ_q == '0) && (infl_cnt == '0);
    assign err     = err_q;

    // Credit counts words already buffered plus words still in the FIFO's read pipe;
    // the same-cycle dequeue frees a slot so a matched depth streams at full rate.
    assign fifo_pop = rst_n && en && !fifo_empty &&
                      (32'(occ_q) + 32'(infl_cnt) < 32'(DEPTH) + 32'(deq));

    assign enq = fifo_valid && exp_vld;
    assign ovf = enq && (occ_q == OW'(DEPTH)) && !deq;
    assign wr  = enq && !ovf;

    always_comb begin
        infl_d[0] = fifo_pop;
        for (int i = 1; i < RD_LAT; i++) infl_d[i] = infl_q[i-1];
    end

    always_comb begin
        head_d = deq ? ptr_inc(head_q) : head_q;
        tail_d = wr  ? ptr_inc(tail_q) : tail_q;
        occ_d  = occ_q;
        if (wr && !deq)      occ_d = occ_q + OW'(1);
        else if (deq && !wr) occ_d = occ_q - OW'(1);
        err_d  = err_q || (fifo_valid != exp_vld) || ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            infl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wr) mem_q[tail_q] <= fifo_rdata;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            infl_q <= infl_d;
            err_q  <= err_d;
        end
    end

    generate
        if (FRAME_LEN > 0) begin : g_frame
            localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          at_end;

            assign at_end = (cnt_q == CW'(FRAME_LEN - 1));
            assign m_last = m_valid && at_end;

            always_comb begin
                cnt_d = cnt_q;
                if (deq) cnt_d = at_end ? '0 : cnt_q + CW'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end else begin : g_noframe
            assign m_last = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_stream_reader.sv
`timescale 1ns/1ps
// Bench for fifo_stream_reader: two instances (RD_LAT=1/DEPTH=2/FRAME_LEN=4 and
// RD_LAT=3/DEPTH=4) fed by behavioural FIFOs, delivered words checked against a scoreboard.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nmis = 0;

    // ---------------- instance A: RD_LAT=1, DEPTH=2, FRAME_LEN=4
    logic        en_a = 0, m_ready_a = 0, inj_a = 0;
    logic        fifo_empty_a, fifo_pop_a, fifo_valid_a, m_valid_a, m_last_a, idle_a, err_a;
    logic [15:0] fifo_rdata_a, m_data_a;
    logic [15:0] fmem_a [64];
    int          wr_a = 0, rd_a = 0;
    logic        pv_a;
    logic [15:0] pd_a;
    logic [15:0] sb_a [$];

    assign fifo_empty_a = (rd_a == wr_a);
    assign fifo_valid_a = pv_a | inj_a;
    assign fifo_rdata_a = pd_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_a <= 1'b0;
            pd_a <= '0;
        end else begin
            pv_a <= fifo_pop_a && !fifo_empty_a;
            pd_a <= fmem_a[rd_a];
            if (fifo_pop_a && !fifo_empty_a) rd_a <= rd_a + 1;
        end
    end

    fifo_stream_reader #(.WIDTH(16), .RD_LAT(1), .DEPTH(2), .FRAME_LEN(4)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .fifo_empty(fifo_empty_a), .fifo_pop(fifo_pop_a),
        .fifo_valid(fifo_valid_a), .fifo_rdata(fifo_rdata_a), .m_valid(m_valid_a),
        .m_ready(m_ready_a), .m_data(m_data_a), .m_last(m_last_a), .idle(idle_a), .err(err_a)
    );

    // ---------------- instance B: RD_LAT=3, DEPTH=4, FRAME_LEN=0
    logic        en_b = 0, m_ready_b = 0;
    logic        fifo_empty_b, fifo_pop_b, fifo_valid_b, m_valid_b, m_last_b, idle_b, err_b;
    logic [15:0] fifo_rdata_b, m_data_b;
    logic [15:0] fmem_b [64];
    int          wr_b = 0, rd_b = 0;
    logic [2:0]  pv_b;
    logic [15:0] pd_b [3];
    logic [15:0] sb_b [$];

    assign fifo_empty_b = (rd_b == wr_b);
    assign fifo_valid_b = pv_b[2];
    assign fifo_rdata_b = pd_b[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_b    <= '0;
            pd_b[0] <= '0;
            pd_b[1] <= '0;
            pd_b[2] <= '0;
        end else begin
            pv_b    <= {pv_b[1:0], fifo_pop_b && !fifo_empty_b};
            pd_b[0] <= fmem_b[rd_b];
            pd_b[1] <= pd_b[0];
            pd_b[2] <= pd_b[1];
            if (fifo_pop_b && !fifo_empty_b) rd_b <= rd_b + 1;
        end
    end

    fifo_stream_reader #(.WIDTH(16), .RD_LAT(3), .DEPTH(4), .FRAME_LEN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .fifo_empty(fifo_empty_b), .fifo_pop(fifo_pop_b),
        .fifo_valid(fifo_valid_b), .fifo_rdata(fifo_rdata_b), .m_valid(m_valid_b),
        .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b), .idle(idle_b), .err(err_b)
    );

    // ---------------- scoreboard monitors (sample on the falling edge)
    int          out_a = 0, beat_a = 0, lasts_a = 0;
    logic        pstall_a = 0;
    logic [15:0] pdata_a = '0;
    initial forever begin
        logic [15:0] e;
        logic        el;
        @(negedge clk);
        if (!rst_n) begin
            out_a = 0; beat_a = 0; lasts_a = 0; pstall_a = 0;
        end else begin
            nvec++;
            if (fifo_pop_a && fifo_empty_a) begin
                nmis++; $display("FAIL a_pop_empty: pop=%b empty=%b, pop must be 0", fifo_pop_a, fifo_empty_a);
            end
            if (pstall_a) begin
                nvec++;
                if (m_valid_a !== 1'b1 || m_data_a !== pdata_a) begin
                    nmis++; $display("FAIL a_hold: valid=%b data=%h want valid=1 data=%h", m_valid_a, m_data_a, pdata_a);
                end
            end
            el = m_valid_a && (beat_a == 3);
            nvec++;
            if (m_last_a !== el) begin
                nmis++; $display("FAIL a_last: got %b want %b (beat %0d)", m_last_a, el, beat_a);
            end
            if (m_valid_a && m_ready_a) begin
                nvec++;
                if (sb_a.size() == 0) begin
                    nmis++; $display("FAIL a_extra: got %h want no beat", m_data_a);
                end else begin
                    e = sb_a.pop_front();
                    if (m_data_a !== e) begin
                        nmis++; $display("FAIL a_data: got %h want %h", m_data_a, e);
                    end
                end
                if (m_last_a) lasts_a++;
                beat_a = (beat_a + 1) % 4;
            end
            out_a = out_a + (fifo_pop_a ? 1 : 0) - ((m_valid_a && m_ready_a) ? 1 : 0);
            nvec++;
            if (out_a > 2 || out_a < 0) begin
                nmis++; $display("FAIL a_outstanding: got %0d want 0..2", out_a);
            end
            pstall_a = m_valid_a && !m_ready_a;
            pdata_a  = m_data_a;
        end
    end

    int          out_b = 0;
    logic        pstall_b = 0;
    logic [15:0] pdata_b = '0;
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        if (!rst_n) begin
            out_b = 0; pstall_b = 0;
        end else begin
            nvec++;
            if (m_last_b !== 1'b0) begin
                nmis++; $display("FAIL b_last: got %b want 0", m_last_b);
            end
            if (pstall_b) begin
                nvec++;
                if (m_valid_b !== 1'b1 || m_data_b !== pdata_b) begin
                    nmis++; $display("FAIL b_hold: valid=%b data=%h want valid=1 data=%h", m_valid_b, m_data_b, pdata_b);
                end
            end
            if (m_valid_b && m_ready_b) begin
                nvec++;
                if (sb_b.size() == 0) begin
                    nmis++; $display("FAIL b_extra: got %h want no beat", m_data_b);
                end else begin
                    e = sb_b.pop_front();
                    if (m_data_b !== e) begin
                        nmis++; $display("FAIL b_data: got %h want %h", m_data_b, e);
                    end
                end
            end
            out_b = out_b + (fifo_pop_b ? 1 : 0) - ((m_valid_b && m_ready_b) ? 1 : 0);
            nvec++;
            if (out_b > 4 || out_b < 0) begin
                nmis++; $display("FAIL b_outstanding: got %0d want 0..4", out_b);
            end
            pstall_b = m_valid_b && !m_ready_b;
            pdata_b  = m_data_b;
        end
    end

    // ---------------- helpers (stimulus only)
    task automatic load_a(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fmem_a[wr_a] = 16'(base + i);
            sb_a.push_back(16'(base + i));
            wr_a++;
        end
    endtask

    task automatic load_b(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fmem_b[wr_b] = 16'(base + i);
            sb_b.push_back(16'(base + i));
            wr_b++;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 0; en_a = 0; en_b = 0; m_ready_a = 0; m_ready_b = 0; inj_a = 0;
        #2;
        wr_a = rd_a; wr_b = rd_b;
        sb_a.delete(); sb_b.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // ---------------- tests
    task automatic test_reset();
        rst_n = 0; en_a = 1; m_ready_a = 1;
        fmem_a[wr_a] = 16'hdead; wr_a++;
        @(negedge clk);
        nvec += 7;
        if (fifo_pop_a !== 1'b0) begin nmis++; $display("FAIL rst_pop: got %b want 0", fifo_pop_a); end
        if (m_valid_a !== 1'b0) begin nmis++; $display("FAIL rst_valid: got %b want 0", m_valid_a); end
        if (m_data_a !== 16'h0) begin nmis++; $display("FAIL rst_data: got %h want 0000", m_data_a); end
        if (m_last_a !== 1'b0) begin nmis++; $display("FAIL rst_last: got %b want 0", m_last_a); end
        if (idle_a !== 1'b1) begin nmis++; $display("FAIL rst_idle: got %b want 1", idle_a); end
        if (err_a !== 1'b0) begin nmis++; $display("FAIL rst_err: got %b want 0", err_a); end
        if (m_valid_b !== 1'b0 || idle_b !== 1'b1 || err_b !== 1'b0 || fifo_pop_b !== 1'b0) begin
            nmis++; $display("FAIL rst_b: valid=%b idle=%b err=%b pop=%b want 0 1 0 0", m_valid_b, idle_b, err_b, fifo_pop_b);
        end
        reset_dut();
    endtask

    task automatic test_stream();
        int fp = -1, fv = -1, lp = 0, ld = 0, np = 0, nd = 0;
        reset_dut();
        @(posedge clk); #1;
        en_a = 1; m_ready_a = 1;
        load_a(8, 1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (fifo_pop_a) begin if (fp < 0) fp = cyc; lp = cyc; np++; end
            if (m_valid_a && m_ready_a) begin if (fv < 0) fv = cyc; ld = cyc; nd++; end
        end
        nvec += 8;
        if (np !== 8) begin nmis++; $display("FAIL stream_npop: got %0d want 8", np); end
        if (lp - fp !== 7) begin nmis++; $display("FAIL stream_pop_span: got %0d want 7", lp - fp); end
        if (nd !== 8) begin nmis++; $display("FAIL stream_nbeat: got %0d want 8", nd); end
        if (ld - fv !== 7) begin nmis++; $display("FAIL stream_beat_span: got %0d want 7", ld - fv); end
        if (fv - fp !== 2) begin nmis++; $display("FAIL stream_latency: got %0d want 2", fv - fp); end
        if (err_a !== 1'b0) begin nmis++; $display("FAIL stream_err: got %b want 0", err_a); end
        if (idle_a !== 1'b1) begin nmis++; $display("FAIL stream_idle: got %b want 1", idle_a); end
        if (sb_a.size() !== 0) begin nmis++; $display("FAIL stream_left: got %0d want 0", sb_a.size()); end
    endtask

    task automatic test_stall();
        reset_dut();
        en_a = 1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (k == 0) load_a(8, 16'h0101);
            m_ready_a = !(k >= 3 && k <= 6);
            @(negedge clk);
            if (k >= 4 && k <= 6) begin
                nvec++;
                if (fifo_pop_a !== 1'b0) begin nmis++; $display("FAIL stall_pop k=%0d: got %b want 0", k, fifo_pop_a); end
            end
            if (k == 5) begin
                nvec++;
                if (m_data_a !== 16'h0102) begin nmis++; $display("FAIL stall_head: got %h want 0102", m_data_a); end
            end
        end
        nvec += 3;
        if (sb_a.size() !== 0) begin nmis++; $display("FAIL stall_left: got %0d want 0", sb_a.size()); end
        if (err_a !== 1'b0) begin nmis++; $display("FAIL stall_err: got %b want 0", err_a); end
        if (idle_a !== 1'b1) begin nmis++; $display("FAIL stall_idle: got %b want 1", idle_a); end
    endtask

    task automatic test_en_gap();
        reset_dut();
        m_ready_a = 1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (k == 0) load_a(8, 16'h0200);
            en_a = !(k >= 3 && k <= 7);
            @(negedge clk);
            if (k == 2) begin
                nvec++;
                if (fifo_pop_a !== 1'b1) begin nmis++; $display("FAIL en_run_pop: got %b want 1", fifo_pop_a); end
            end
            if (!en_a) begin
                nvec++;
                if (fifo_pop_a !== 1'b0) begin nmis++; $display("FAIL en_off_pop k=%0d: got %b want 0", k, fifo_pop_a); end
            end
            if (k == 7) begin
                nvec++;
                if (idle_a !== 1'b1) begin nmis++; $display("FAIL en_off_idle: got %b want 1", idle_a); end
            end
        end
        nvec += 2;
        if (sb_a.size() !== 0) begin nmis++; $display("FAIL en_left: got %0d want 0", sb_a.size()); end
        if (err_a !== 1'b0) begin nmis++; $display("FAIL en_err: got %b want 0", err_a); end
    endtask

    task automatic test_frame();
        reset_dut();
        en_a = 1;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (k == 0) load_a(10, 16'h0300);
            m_ready_a = !(k >= 5 && k <= 7);
            @(negedge clk);
            if (k == 6) begin
                nvec++;
                if (m_last_a !== 1'b1 || m_data_a !== 16'h0303) begin
                    nmis++; $display("FAIL frame_stall_last: last=%b data=%h want 1 0303", m_last_a, m_data_a);
                end
            end
        end
        @(posedge clk); #1;
        nvec += 2;
        if (lasts_a !== 2) begin nmis++; $display("FAIL frame_nlast: got %0d want 2", lasts_a); end
        if (sb_a.size() !== 0) begin nmis++; $display("FAIL frame_left: got %0d want 0", sb_a.size()); end
    endtask

    task automatic test_err();
        reset_dut();
        @(posedge clk); #1 inj_a = 1;
        @(negedge clk);
        nvec++;
        if (err_a !== 1'b0) begin nmis++; $display("FAIL err_early: got %b want 0", err_a); end
        @(posedge clk); #1 inj_a = 0;
        @(negedge clk);
        nvec += 2;
        if (err_a !== 1'b1) begin nmis++; $display("FAIL err_set: got %b want 1", err_a); end
        if (m_valid_a !== 1'b0) begin nmis++; $display("FAIL err_noenq: got %b want 0", m_valid_a); end
        repeat (5) @(negedge clk);
        nvec++;
        if (err_a !== 1'b1) begin nmis++; $display("FAIL err_sticky: got %b want 1", err_a); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        en_a = 1; m_ready_a = 0;
        load_a(8, 16'h0400);
        repeat (4) @(negedge clk);
        nvec++;
        if (m_valid_a !== 1'b1) begin nmis++; $display("FAIL areset_pre: got %b want 1", m_valid_a); end
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        nvec += 2;
        if (m_valid_a !== 1'b0) begin nmis++; $display("FAIL areset_valid: got %b want 0", m_valid_a); end
        if (fifo_pop_a !== 1'b0) begin nmis++; $display("FAIL areset_pop: got %b want 0", fifo_pop_a); end
        en_a = 0;
        wr_a = rd_a;
        sb_a.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        nvec += 2;
        if (idle_a !== 1'b1) begin nmis++; $display("FAIL areset_idle: got %b want 1", idle_a); end
        if (err_a !== 1'b0) begin nmis++; $display("FAIL areset_err: got %b want 0", err_a); end
        repeat (4) @(negedge clk);
        nvec++;
        if (err_a !== 1'b0) begin nmis++; $display("FAIL areset_err_after: got %b want 0", err_a); end
    endtask

    task automatic test_random_lat3();
        int k = 0;
        reset_dut();
        @(posedge clk); #1;
        en_b = 1;
        load_b(16, 16'h0a00);
        while (sb_b.size() != 0 && k < 400) begin
            @(posedge clk); #1;
            m_ready_b = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            k++;
        end
        nvec++;
        if (sb_b.size() !== 0) begin nmis++; $display("FAIL rand_timeout: got %0d left want 0", sb_b.size()); end
        @(posedge clk); #1 m_ready_b = 1;
        repeat (6) @(negedge clk);
        nvec += 3;
        if (err_b !== 1'b0) begin nmis++; $display("FAIL rand_err: got %b want 0", err_b); end
        if (idle_b !== 1'b1) begin nmis++; $display("FAIL rand_idle: got %b want 1", idle_b); end
        if (m_valid_b !== 1'b0) begin nmis++; $display("FAIL rand_valid: got %b want 0", m_valid_b); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_en_gap();
        test_frame();
        test_err();
        test_async_reset();
        test_random_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
